// File: rtl/stream_checksum.sv
// Streaming RFC 1071 Internet checksum engine.
// Beats arrive on a valid/ready stream with byte keep and last marking. A
// 16-bit one's-complement sum is accumulated across the packet, and the
// checksum (~sum) plus a verify flag is then offered on a result handshake.
// DATA_W must be a multiple of 16 and at least 16.

// Per-lane byte masking: keep[1] qualifies the high (first on the wire) byte.
module csum_lane (
  input  logic [15:0] data,
  input  logic [1:0]  keep,
  output logic [15:0] masked
);
  assign masked = {keep[1] ? data[15:8] : 8'h00,
                   keep[0] ? data[7:0]  : 8'h00};
endmodule

module stream_checksum #(
  parameter int          DATA_W   = 32,
  parameter logic [15:0] INIT_SUM = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                csum_valid,
  input  logic                csum_ready,
  output logic [15:0]         csum,
  output logic                csum_ok
);
  localparam int NLANE = DATA_W / 16;
  localparam int KW    = DATA_W / 8;
  // Lane sum width, plus one bit of headroom for adding the accumulator.
  localparam int LW    = 16 + $clog2(NLANE + 1);
  localparam int RW    = LW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]             acc;
  logic [15:0]             csum_q;
  logic                    ok_q;
  logic [NLANE-1:0][15:0]  lane;
  logic [LW-1:0]           lane_sum;
  logic [15:0]             base;
  logic [RW-1:0]           raw;
  logic [16:0]             fold1;
  logic [15:0]             fold2;
  logic                    fire;

  // Lane 0 is the most-significant 16 bits of the beat (network order).
  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    csum_lane u_lane (
      .data   (in_data[DATA_W-1-16*g -: 16]),
      .keep   (in_keep[KW-1-2*g -: 2]),
      .masked (lane[g])
    );
  end

  // Ready is dropped combinationally during reset so nothing is accepted then.
  assign in_ready   = !rst && (state != DONE);
  assign fire       = in_valid && in_ready;
  assign csum_valid = (state == DONE);
  assign csum       = csum_q;
  assign csum_ok    = ok_q;

  // A packet's first beat adds onto INIT_SUM regardless of what acc holds.
  assign base = (state == IDLE) ? INIT_SUM : acc;

  // Sum all lanes of the beat into a wide raw value.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NLANE; i++)
      lane_sum = lane_sum + LW'(lane[i]);
  end

  // Add the running sum, then two end-around-carry folds bring it to 16 bits;
  // the second fold can only carry when the first left a tiny low half.
  assign raw   = RW'(lane_sum) + RW'(base);
  assign fold1 = 17'(raw[15:0]) + 17'(raw[RW-1:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: beats accumulate until last, then hold for the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (fire) state_nxt = in_last ? DONE : ACCUM;
      DONE:        if (csum_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Accumulator and result registers; the result holds after hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= INIT_SUM;
      csum_q <= 16'h0000;
      ok_q   <= 1'b0;
    end else if (fire) begin
      acc <= fold2;
      if (in_last) begin
        csum_q <= ~fold2;
        ok_q   <= (fold2 == 16'hFFFF);
      end
    end else if (state == DONE && csum_ready) begin
      acc <= INIT_SUM;
    end
  end
endmodule

// File: tb/tb_stream_checksum.sv
// Bench for stream_checksum: directed vectors, backpressure, mid-packet
// reset, a 64-bit instance and randomized packets against a byte-level model.
`timescale 1ns/1ps
module tb_stream_checksum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        csum_valid, csum_ready, csum_ok;
  logic [15:0] csum;

  logic        w_valid, w_ready, w_last, w_cv, w_cr, w_ok;
  logic [63:0] w_data;
  logic [7:0]  w_keep;
  logic [15:0] w_csum;

  int errs = 0;
  int checks = 0;
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  stream_checksum #(.DATA_W(32), .INIT_SUM(16'h0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .csum_valid(csum_valid), .csum_ready(csum_ready), .csum(csum),
    .csum_ok(csum_ok));

  stream_checksum #(.DATA_W(64), .INIT_SUM(16'h0000)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready),
    .in_data(w_data), .in_keep(w_keep), .in_last(w_last),
    .csum_valid(w_cv), .csum_ready(w_cr), .csum(w_csum),
    .csum_ok(w_ok));

  // Reference: plain integer sum of 16-bit words over the masked byte stream,
  // folded at the end.
  function automatic logic [15:0] model_sum();
    int unsigned s = 0;
    for (int i = 0; i < pkt.size(); i += 2) s += {pkt[i], pkt[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  // Present one beat and wait (bounded) for acceptance; returns at edge+1.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc = 0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errs++;
      $display("FAIL accept_timeout: beat %h never accepted, required acceptance", d);
    end else begin
      for (int b = 0; b < 4; b++) pkt.push_back(k[3-b] ? d[31-8*b -: 8] : 8'h00);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks += 4;
    if (in_ready !== 1'b0)     begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (csum_valid !== 1'b0)   begin errs++; $display("FAIL rst_csum_valid: got %b want 0", csum_valid); end
    if (csum !== 16'h0000)     begin errs++; $display("FAIL rst_csum: got %h want 0000", csum); end
    if (csum_ok !== 1'b0)      begin errs++; $display("FAIL rst_csum_ok: got %b want 0", csum_ok); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    if (w_ready !== 1'b1)  begin errs++; $display("FAIL post_rst_w_ready: got %b want 1", w_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] td[5][3];
    logic [3:0]  tk[5][3];
    int          tn[5];
    logic [15:0] te[5];
    logic        to[5];
    td[0] = '{32'h0001F203, 32'hF4F5F6F7, 32'h0};   tk[0] = '{4'hF, 4'hF, 4'hF}; tn[0] = 2; te[0] = 16'h220D; to[0] = 0;
    td[1] = '{32'h0001F203, 32'hF4F5F6F7, 32'h220D0000}; tk[1] = '{4'hF, 4'hF, 4'hF}; tn[1] = 3; te[1] = 16'h0000; to[1] = 1;
    td[2] = '{32'hFFFF0001, 32'h0, 32'h0};          tk[2] = '{4'hF, 4'hF, 4'hF}; tn[2] = 1; te[2] = 16'hFFFE; to[2] = 0;
    td[3] = '{32'h12345678, 32'h0, 32'h0};          tk[3] = '{4'hE, 4'hF, 4'hF}; tn[3] = 1; te[3] = 16'h97CB; to[3] = 0;
    td[4] = '{32'h00000000, 32'h0, 32'h0};          tk[4] = '{4'hF, 4'hF, 4'hF}; tn[4] = 2; te[4] = 16'hFFFF; to[4] = 0;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < tn[p]; b++) send_beat(td[p][b], tk[p][b], b == tn[p]-1);
      checks += 4;
      if (csum_valid !== 1'b1) begin errs++; $display("FAIL dir%0d_latency: csum_valid %b want 1", p, csum_valid); end
      if (csum !== te[p])      begin errs++; $display("FAIL dir%0d_csum: got %h want %h", p, csum, te[p]); end
      if (csum_ok !== to[p])   begin errs++; $display("FAIL dir%0d_ok: got %b want %b", p, csum_ok, to[p]); end
      if (in_ready !== 1'b0)   begin errs++; $display("FAIL dir%0d_ready_done: got %b want 0", p, in_ready); end
      csum_ready = 1'b1;
      @(posedge clk); #1;
      csum_ready = 1'b0;
      checks += 3;
      if (csum_valid !== 1'b0) begin errs++; $display("FAIL dir%0d_valid_drop: got %b want 0", p, csum_valid); end
      if (in_ready !== 1'b1)   begin errs++; $display("FAIL dir%0d_ready_back: got %b want 1", p, in_ready); end
      if (csum !== te[p])      begin errs++; $display("FAIL dir%0d_csum_hold: got %h want %h", p, csum, te[p]); end
      pkt.delete();
    end
  endtask

  task automatic test_backpressure();
    send_beat(32'hFFFF0001, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (csum_valid !== 1'b1 || csum !== 16'hFFFE || csum_ok !== 1'b0 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold%0d: valid=%b csum=%h ok=%b ready=%b want 1 FFFE 0 0",
                 c, csum_valid, csum, csum_ok, in_ready);
      end
    end
    csum_ready = 1'b1;
    @(posedge clk); #1;
    csum_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    send_beat(32'h00010002, 4'hF, 1'b1);
    checks++;
    if (csum !== 16'hFFFC) begin errs++; $display("FAIL bp_no_carryover: got %h want FFFC", csum); end
    csum_ready = 1'b1;
    @(posedge clk); #1;
    csum_ready = 1'b0;
    pkt.delete();
  endtask

  task automatic test_reset_mid();
    send_beat(32'hFFFFFFFF, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (in_ready !== 1'b0)   begin errs++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    if (csum_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b want 0", csum_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (csum_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_no_pulse: got %b want 0", csum_valid); end
    send_beat(32'h00010002, 4'hF, 1'b1);
    checks += 2;
    if (csum !== 16'hFFFC)   begin errs++; $display("FAIL mid_rst_csum: got %h want FFFC", csum); end
    if (csum_valid !== 1'b1) begin errs++; $display("FAIL mid_rst_valid_after: got %b want 1", csum_valid); end
    csum_ready = 1'b1;
    @(posedge clk); #1;
    csum_ready = 1'b0;
    pkt.delete();
  endtask

  task automatic test_wide();
    logic [63:0] wd[2];
    bit acc;
    wd = '{64'h0001F203F4F5F6F7, 64'h220D000000000000};
    for (int b = 0; b < 2; b++) begin
      w_data = wd[b]; w_keep = 8'hFF; w_last = (b == 1); w_valid = 1'b1;
      acc = 0;
      for (int n = 0; n < 50; n++) begin
        if (w_ready) begin @(posedge clk); #1; acc = 1; break; end
        @(posedge clk); #1;
      end
      w_valid = 1'b0;
      checks++;
      if (!acc) begin errs++; $display("FAIL wide_accept%0d: timeout, required acceptance", b); end
    end
    checks += 3;
    if (w_cv !== 1'b1)       begin errs++; $display("FAIL wide_valid: got %b want 1", w_cv); end
    if (w_csum !== 16'h0000) begin errs++; $display("FAIL wide_csum: got %h want 0000", w_csum); end
    if (w_ok !== 1'b1)       begin errs++; $display("FAIL wide_ok: got %b want 1", w_ok); end
    w_cr = 1'b1;
    @(posedge clk); #1;
    w_cr = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] s;
    int nb, hold;
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat($urandom, 4'($urandom), b == nb-1);
      end
      s = model_sum();
      checks += 3;
      if (csum_valid !== 1'b1)        begin errs++; $display("FAIL rnd%0d_valid: got %b want 1", p, csum_valid); end
      if (csum !== ~s)                begin errs++; $display("FAIL rnd%0d_csum: got %h want %h", p, csum, ~s); end
      if (csum_ok !== (s == 16'hFFFF)) begin errs++; $display("FAIL rnd%0d_ok: got %b want %b", p, csum_ok, s == 16'hFFFF); end
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      checks++;
      if (csum !== ~s || csum_valid !== 1'b1) begin
        errs++; $display("FAIL rnd%0d_hold: csum=%h valid=%b want %h 1", p, csum, csum_valid, ~s);
      end
      csum_ready = 1'b1;
      @(posedge clk); #1;
      csum_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_data = '0; in_keep = '0; in_last = 0; csum_ready = 0;
    w_valid = 0; w_data = '0; w_keep = '0; w_last = 0; w_cr = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
